// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// the byte-enable pattern that denotes a read.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter. The requester (core LSU or
// debug/DMA master) uses the master modport; the arbiter uses the slave one.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [3:0]            we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, we, addr, wdata, lock,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, lock,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick. rr_ptr names the master granted most recently;
// on a contested cycle the other master wins.
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic gnt0,
    output logic gnt1
);

    // Grant the lone requester, or the one that did not go last.
    always_comb begin
        gnt0 = req0 && (!req1 || rr_ptr);
        gnt1 = req1 && (!req0 || !rr_ptr);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port byte-writable data SRAM.
// Port m0 is the core load/store unit, m1 the debug/DMA master. One access is
// granted per cycle; the 1-cycle-latency read data is routed back to the
// master that issued it. A transfer with lock=1 keeps the grant for that
// master (atomic read-modify-write) until it transfers with lock=0.
// Optional feature macro: DMEM_ARB_PERF_EN adds perf_grant0/perf_grant1/
// perf_stall counters. DATA_WIDTH must be 32 (four byte enables).
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         m0,
    dmem_arbiter_if.slave         m1,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_stall
`endif
);

    arb_state_e            state_q, state_d;
    logic                  rr_q, rr_d;          // last granted master
    logic                  inflight_q, inflight_d;
    logic                  owner_q, owner_d;    // 1: in-flight access is m1's
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic pick_gnt0, pick_gnt1;
    logic gnt0, gnt1;
    logic rvalid0, rvalid1;

    dmem_rr_pick u_rr_pick (
        .req0   (m0.valid),
        .req1   (m1.valid),
        .rr_ptr (rr_q),
        .gnt0   (pick_gnt0),
        .gnt1   (pick_gnt1)
    );

    // Grant: round-robin in ARB, locked owner only in LOCKN, nothing in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    gnt0 = pick_gnt0;
                    gnt1 = pick_gnt1;
                end
                LOCK0:   gnt0 = m0.valid;
                LOCK1:   gnt1 = m1.valid;
                default: ;
            endcase
        end
    end

    // Next state, round-robin pointer and in-flight tag from the granted transfer.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        inflight_d = gnt0 || gnt1;
        owner_d    = gnt1;
        if (gnt0) begin
            rr_d    = 1'b0;
            state_d = m0.lock ? LOCK0 : ARB;
        end else if (gnt1) begin
            rr_d    = 1'b1;
            state_d = m1.lock ? LOCK1 : ARB;
        end
    end

    // SRAM bus mirrors the granted request; idle cycles disable the SRAM.
    always_comb begin
        sram_en   = gnt0 || gnt1;
        sram_we   = WE_READ;
        sram_addr = m0.addr;
        sram_din  = m0.wdata;
        if (gnt0) begin
            sram_we = m0.we;
        end else if (gnt1) begin
            sram_we   = m1.we;
            sram_addr = m1.addr;
            sram_din  = m1.wdata;
        end
    end

    // Response routing: the tag picks the owner; rdata holds between pulses.
    always_comb begin
        rvalid0  = !rst && inflight_q && !owner_q;
        rvalid1  = !rst && inflight_q &&  owner_q;
        rdata0_d = rvalid0 ? sram_dout : rdata0_q;
        rdata1_d = rvalid1 ? sram_dout : rdata1_q;

        m0.ready  = gnt0;
        m1.ready  = gnt1;
        m0.rvalid = rvalid0;
        m1.rvalid = rvalid1;
        m0.rdata  = rdata0_d;
        m1.rdata  = rdata1_d;
    end

    // State registers; reset drops any lock and the pending response.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= ARB;
            rr_q       <= 1'b1;
            inflight_q <= 1'b0;
            owner_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
            owner_q    <= owner_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant0_d;
    logic [31:0] perf_grant1_q, perf_grant1_d;
    logic [31:0] perf_stall_q,  perf_stall_d;
    logic        stalled;

    // Counter increments: transfers per master and cycles with a waiting master.
    always_comb begin
        stalled       = (m0.valid && !gnt0) || (m1.valid && !gnt1);
        perf_grant0_d = perf_grant0_q + {31'd0, gnt0};
        perf_grant1_d = perf_grant1_q + {31'd0, gnt1};
        perf_stall_d  = perf_stall_q  + {31'd0, stalled};
    end

    // Wrapping counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0_q <= '0;
            perf_grant1_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_grant0_q <= perf_grant0_d;
            perf_grant1_q <= perf_grant1_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_grant0 = perf_grant0_q;
    assign perf_grant1 = perf_grant1_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
